// File: rtl/led_pkg.sv
// led_pkg: shared FSM state encoding and character geometry for the LED message scroller.
package led_pkg;
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PRESENT = 2'd1,
    WAIT    = 2'd2
  } state_t;
  localparam int CHAR_W = 4;
  localparam int DIGITS = 4;
endpackage

// File: rtl/led_scroll_timer.sv
// led_scroll_timer: prescaler counting 0..PERIOD-1 that pulses tick on the last count and freezes while paused.
module led_scroll_timer #(
  parameter int unsigned PERIOD = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic tick
);
  localparam int W = $clog2(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    tick    = !pause && count_q == LAST;
    count_d = pause ? count_q : tick ? '0 : count_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/led_message_scroller.sv
// led_message_scroller: scrolls a 16-character hex message through a 4-digit window with a valid/ready frame handshake.
// Optional LED_SCROLL_BIDIR_EN adds a dir input that selects decrementing scroll.
module led_message_scroller
  import led_pkg::*;
#(
  parameter int unsigned SCROLL_PERIOD = 50000000,
  parameter int unsigned MSG_LEN       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [CHAR_W-1:0]        wr_data,
  input  logic                     pause,
  input  logic                     frame_ready,
`ifdef LED_SCROLL_BIDIR_EN
  input  logic                     dir,
`endif
  output logic                     frame_valid,
  output logic [DIGITS*CHAR_W-1:0] frame_chars,
  output logic [3:0]               ptr
);
  state_t                     state_q, state_d;
  logic [3:0]                 ptr_q, ptr_d, ptr_step;
  logic                       pending_q, pending_d;
  logic [DIGITS*CHAR_W-1:0]   frame_q, frame_d;
  logic [CHAR_W-1:0]          msg_q [MSG_LEN];
  logic [CHAR_W-1:0]          msg_d [MSG_LEN];
  logic                       tick;

  led_scroll_timer #(.PERIOD(SCROLL_PERIOD)) u_timer (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .tick  (tick)
  );

`ifdef LED_SCROLL_BIDIR_EN
  assign ptr_step = dir ? ptr_q - 4'd1 : ptr_q + 4'd1;
`else
  assign ptr_step = ptr_q + 4'd1;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    msg_d     = msg_q;
    if (wr_en) msg_d[wr_addr] = wr_data;
    unique case (state_q)
      LOAD: begin
        frame_d   = {msg_q[ptr_q], msg_q[ptr_q + 4'd1], msg_q[ptr_q + 4'd2], msg_q[ptr_q + 4'd3]};
        pending_d = pending_q | tick;
        state_d   = PRESENT;
      end
      PRESENT: begin
        pending_d = pending_q | tick;
        state_d   = frame_ready ? WAIT : PRESENT;
      end
      WAIT: begin
        if (tick || pending_q) begin
          ptr_d     = ptr_step;
          pending_d = 1'b0;
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= CHAR_W'(i);
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      msg_q     <= msg_d;
    end
  end

  assign frame_valid = state_q == PRESENT;
  assign frame_chars = frame_q;
  assign ptr         = ptr_q;
endmodule

// File: doc/led_message_scroller.md
LED_MESSAGE_SCROLLER -- requirements
Module: led_message_scroller

Interface
REQ-001 Parameter SCROLL_PERIOD, default 50000000, clk cycles between scroll steps; legal range is 2 or more.
REQ-002 Parameter MSG_LEN, default 16, number of 4-bit characters in the message buffer; fixed at 16 in this revision.
REQ-003 The module SHALL have exactly one clock and reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  message write strobe.
REQ-007 wr_addr  input  4  message character index.
REQ-008 wr_data  input  4  character code, hex digit 0-F.
REQ-009 pause  input  1  freezes the scroll timer while high.
REQ-010 frame_ready  input  1  display driver accepts the current frame.
REQ-011 frame_valid  output  1  frame on frame_chars is valid.
REQ-012 frame_chars  output  16  four characters, [15:12]=an3 digit through [3:0]=an0 digit.
REQ-013 ptr  output  4  index of the leftmost displayed character.

Function
REQ-014 Message buffer: 16x4 registers; wr_en writes wr_data to entry wr_addr on the clk edge.
REQ-015 Scroll timer: counts 0..SCROLL_PERIOD-1 and wraps; tick is a one-cycle pulse at count SCROLL_PERIOD-1; count holds while pause=1.
REQ-016 FSM states are LOAD, PRESENT and WAIT.
REQ-017 LOAD: frame_chars <= {msg[ptr], msg[ptr+1], msg[ptr+2], msg[ptr+3]}, indices mod 16; next state PRESENT.
REQ-018 PRESENT: frame_valid=1 and frame_chars stable; on frame_ready=1 go to WAIT.
REQ-019 WAIT: frame_valid=0; on tick or pending=1, ptr <= ptr+1 (or ptr-1, see Configuration), clear pending, go to LOAD.
REQ-020 Latency: frame_valid rises 2 cycles after the advancing tick (WAIT->LOAD->PRESENT).
REQ-021 A tick in LOAD or PRESENT sets pending; pending holds at most one step, and further ticks while pending=1 are dropped.
REQ-022 ptr wraps 15->0 (increment) and 0->15 (decrement).
REQ-023 A write to an entry in the same cycle LOAD captures that entry: LOAD captures the old value and the write lands.
REQ-024 Writes never alter a frame already latched in frame_chars.
REQ-025 frame_ready while frame_valid=0 is ignored.

Reset
REQ-026 On reset assertion, all of the following apply asynchronously: state=LOAD, ptr=0, timer=0, pending=0, frame_valid=0, frame_chars=16'h0000, msg[i]=i for i=0..15.
REQ-027 Reset asserted mid-frame discards the frame and any pending step.
REQ-028 After reset deasserts, the first frame (16'h0123) is valid on the 2nd rising edge.

Configuration
REQ-029 Macro LED_SCROLL_BIDIR_EN: when defined, add input dir (1 bit); dir=1 decrements ptr in WAIT, dir=0 increments; dir is sampled at the advancing edge.
REQ-030 Without LED_SCROLL_BIDIR_EN: no dir port, and ptr always increments.

Structure
REQ-031 Shared package led_pkg holds the FSM state encoding (LOAD=2'd0, PRESENT=2'd1, WAIT=2'd2), the character width (4) and the digit count (4).
REQ-032 Sub-module led_scroll_timer holds the prescaler counter with pause and tick output; the FSM and message buffer stay in led_message_scroller.

Verification (SCROLL_PERIOD=4 on the bench)
REQ-033 Reset release, frame_ready=1 constant -> frame_valid=1 with 16'h0123 on the 2nd edge; next frame 16'h1234 follows the next tick.
REQ-034 Scroll to ptr=14 -> frame_chars=16'hEF01; next step ptr=15 gives 16'hF012; following step ptr=0 gives 16'h0123.
REQ-035 Hold frame_ready=0 for 12 cycles (3 ticks) -> frame held stable, pending=1; on ready, exactly one step is taken, ptr advances by 1, not 3.
REQ-036 Write msg[2]=4'hA in the LOAD cycle for ptr=0 -> frame 16'h0123; after wrap back to ptr=0 the frame shows 16'h01A3.
REQ-037 pause=1 for 20 cycles -> ptr unchanged and no new frame; the timer resumes from its held count.
REQ-038 With LED_SCROLL_BIDIR_EN and dir=1 from ptr=0 -> ptr=15, frame_chars=16'hF012; assert reset mid-PRESENT -> frame_valid=0 immediately and the frame returns to 16'h0123 after release.
